// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared HI/LO mul/div width and op encoding
package mips_pkg;

  localparam int MULDIV_W = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } muldiv_op_e;

endpackage

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - unsigned restoring divider, one quotient bit per step
module divider_iter
  import mips_pkg::*;
#(
  parameter int W = MULDIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         last_step
);

  logic [W-1:0] rem_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] div_q;
  logic [5:0]   cnt_q;
  logic [W:0]   rem_sh;
  logic [W:0]   diff;

  // Dividend bits shift out of the quotient register into the partial remainder.
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, div_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      if (!diff[W]) begin
        rem_q <= diff[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign last_step = (cnt_q == 6'(W - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO registers with single-cycle multiply and 33-cycle divide
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int W = MULDIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  input  logic         flush,
  output logic         busy,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]     state_q;
  logic           q_neg_q;
  logic           r_neg_q;
  muldiv_op_e     op_e;
  logic           accept;
  logic           is_div;
  logic           div_start;
  logic           rs_neg;
  logic           rt_neg;
  logic [W-1:0]   rs_mag;
  logic [W-1:0]   rt_mag;
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] prod_u;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           last_step;

  assign op_e      = muldiv_op_e'(op);
  assign accept    = start && !flush && (state_q == ST_IDLE);
  assign is_div    = (op_e == OP_DIV) || (op_e == OP_DIVU);
  assign div_start = accept && is_div && (rt != '0);

  // Signed divide runs on magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude.
  assign rs_neg = (op_e == OP_DIV) && rs[W-1];
  assign rt_neg = (op_e == OP_DIV) && rt[W-1];
  assign rs_mag = rs_neg ? -rs : rs;
  assign rt_mag = rt_neg ? -rt : rt;

  // Low 2W bits of the sign-extended product equal the signed product.
  assign prod_s = {{W{rs[W-1]}}, rs} * {{W{rt[W-1]}}, rt};
  assign prod_u = {{W{1'b0}}, rs} * {{W{1'b0}}, rt};

  divider_iter #(.W(W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .load      (div_start),
    .step      (state_q == ST_DIV),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .quotient  (quotient),
    .remainder (remainder),
    .last_step (last_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (flush && (state_q != ST_IDLE)) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op_e)
              OP_MULT:  {hi, lo} <= prod_s;
              OP_MULTU: {hi, lo} <= prod_u;
              OP_DIV, OP_DIVU: begin
                if (rt == '0) begin
                  lo <= '1;
                  hi <= rs;
                end else begin
                  state_q <= ST_DIV;
                  q_neg_q <= rs_neg ^ rt_neg;
                  r_neg_q <= rs_neg;
                end
              end
              OP_MTHI:  hi <= rs;
              OP_MTLO:  lo <= rs;
              default:  ;
            endcase
          end
        end
        ST_DIV: begin
          if (last_step) state_q <= ST_FIX;
        end
        ST_FIX: begin
          lo      <= q_neg_q ? -quotient : quotient;
          hi      <= r_neg_q ? -remainder : remainder;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have parameter W, default 32, giving the operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, request to execute op on rs/rt this cycle.
REQ-005 SHALL have port op, input, 3 bits, operation select: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
REQ-006 SHALL have port rs, input, W bits, first operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 SHALL have port rt, input, W bits, second operand: multiplier or divisor.
REQ-008 SHALL have port flush, input, 1 bit, abort any in-progress divide.
REQ-009 SHALL have port busy, output, 1 bit, high while a divide is in progress; the CPU stalls MFHI/MFLO and new muldiv ops while it is high.
REQ-010 SHALL have ports hi and lo, outputs, W bits each, the architectural HI/LO registers, driven directly from flops.

Function
REQ-011 SHALL implement an FSM with states IDLE, DIV and FIX.
REQ-012 In IDLE, start with MULT/MULTU SHALL write the 64-bit product at that edge: hi = upper 32 bits, lo = lower 32 bits (signed for MULT, unsigned for MULTU); busy stays 0.
REQ-013 In IDLE, start with MTHI SHALL write hi = rs, and start with MTLO SHALL write lo = rs, at that edge; the other register is unchanged.
REQ-014 In IDLE, start with DIV/DIVU and rt != 0 SHALL latch the operand magnitudes and the sign flags, then go to DIV; busy = 1 from the next cycle.
REQ-015 DIV SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, then go to FIX.
REQ-016 FIX SHALL write lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend (signed DIV), return to IDLE, and deassert busy.
REQ-017 Division latency: start sampled at edge 0; busy high after edges 0..32; hi/lo updated and busy low after edge 33.
REQ-018 Divide by zero (rt == 0, DIV or DIVU) SHALL complete at edge 0 with lo = 32'hFFFFFFFF and hi = rs; busy stays 0.
REQ-019 DIV of 32'h80000000 by -1 SHALL give lo = 32'h80000000 and hi = 0.
REQ-020 start SHALL be ignored while busy = 1.
REQ-021 flush in DIV or FIX SHALL return the FSM to IDLE at the next edge with hi/lo unchanged and busy low after that edge.
REQ-022 flush and start high together SHALL be resolved in favour of flush: no operation executes.
REQ-023 hi and lo SHALL be unchanged on every cycle without a completing operation.

Reset
REQ-024 reset high SHALL immediately force state IDLE, busy = 0, hi = 0, lo = 0, iteration counter = 0, independent of clk.
REQ-025 reset asserted mid-divide SHALL discard the division; no partial result reaches hi/lo.
REQ-026 After reset release, the first rising edge SHALL accept start normally.

Structure
REQ-027 The op encoding enum and the width constant SHALL live in shared package mips_pkg.
REQ-028 The iterative divide datapath (remainder/quotient registers, 6-bit counter, subtractor) SHALL be sub-module divider_iter; sign handling, FSM and HI/LO registers stay in the top.

Verification
REQ-029 MULT rs=10, rt=-7 -> after edge 0: lo = 32'hFFFFFFBA (-70), hi = 32'hFFFFFFFF, busy never high.
REQ-030 DIV rs=-7, rt=2 -> busy high for 33 cycles, then lo = 32'hFFFFFFFD (-3), hi = 32'hFFFFFFFF (-1).
REQ-031 DIVU rs=21, rt=4 -> after edge 33: lo = 5, hi = 1; a MULTU start issued at edge 10 is ignored.
REQ-032 DIV rs=100, rt=0 -> same edge: lo = 32'hFFFFFFFF, hi = 100, busy = 0.
REQ-033 MTHI rs=32'hA5A5A5A5 -> hi updated, lo unchanged; then DIVU 50/7 flushed at cycle 5 -> hi/lo unchanged, busy low next cycle.
REQ-034 Reset pulsed mid-DIV -> hi = lo = 0 and busy = 0 immediately, without a clock edge.
